// File: rtl/mult_arbiter_pkg.sv
// Shared types, defaults and helpers for the round-robin multiplier arbiter.
package mult_arbiter_pkg;

  localparam int unsigned DefNumReq     = 4;
  localparam int unsigned DefInputWidth = 16;
  localparam int unsigned DefLatency    = 3;

  // Requester index width; a single-bit id is kept even for tiny configurations.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefIdW   = id_width(DefNumReq);
  localparam int unsigned DefProdW = 2 * DefInputWidth;

  typedef struct packed {
    logic                valid;
    logic [DefIdW-1:0]   id;
    logic [DefProdW-1:0] product;
  } pipe_stage_t;

endpackage

// File: rtl/mult_pipe.sv
// Pipelined full-width multiplier; the id tag rides alongside the product.
module mult_pipe #(
  parameter int unsigned INPUT_WIDTH = 16,
  parameter int unsigned LATENCY     = 3,
  parameter bit          IS_SIGNED   = 1'b0,
  parameter int unsigned ID_W        = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [ID_W-1:0]          in_id,
  input  logic [INPUT_WIDTH-1:0]   in0,
  input  logic [INPUT_WIDTH-1:0]   in1,
  output logic                     out_valid,
  output logic [ID_W-1:0]          out_id,
  output logic [2*INPUT_WIDTH-1:0] product
);

  localparam int unsigned ProdW = 2 * INPUT_WIDTH;

  typedef struct packed {
    logic             valid;
    logic [ID_W-1:0]  id;
    logic [ProdW-1:0] product;
  } stage_t;

  logic [ProdW-1:0] a_ext, b_ext;
  stage_t           stage_in;
  stage_t [LATENCY-1:0] stage_q;

  // Extending both operands to the full product width makes the low 2W bits of
  // an ordinary multiply correct for either signedness.
  always_comb begin
    if (IS_SIGNED) begin
      a_ext = {{INPUT_WIDTH{in0[INPUT_WIDTH-1]}}, in0};
      b_ext = {{INPUT_WIDTH{in1[INPUT_WIDTH-1]}}, in1};
    end else begin
      a_ext = {{INPUT_WIDTH{1'b0}}, in0};
      b_ext = {{INPUT_WIDTH{1'b0}}, in1};
    end
    stage_in.valid   = in_valid;
    stage_in.id      = in_id;
    stage_in.product = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (en) begin
      stage_q[0] <= stage_in;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid = stage_q[LATENCY-1].valid;
  assign out_id    = stage_q[LATENCY-1].id;
  assign product   = stage_q[LATENCY-1].product;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters.
// Optional per-requester grant counters: define MULT_ARBITER_STATS_EN.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DefNumReq,
  parameter int unsigned INPUT_WIDTH = DefInputWidth,
  parameter int unsigned LATENCY     = DefLatency,
  parameter bit          IS_SIGNED   = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][INPUT_WIDTH-1:0] req_in0,
  input  logic [NUM_REQ-1:0][INPUT_WIDTH-1:0] req_in1,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [id_width(NUM_REQ)-1:0]        out_id,
  output logic [INPUT_WIDTH-1:0]              out_high,
  output logic [INPUT_WIDTH-1:0]              out_low
`ifdef MULT_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]            grant_count
`endif
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic                     stall;
  logic                     grant_found;
  int unsigned              grant_idx;
  int unsigned              cand;
  logic                     xfer;
  logic [ID_W-1:0]          grant_id;
  logic [2*INPUT_WIDTH-1:0] product;

  assign stall = out_valid & ~out_ready;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 0;
    cand        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr_q) + i) % NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // rst_n gates the ready so no requester sees an accept while held in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && !stall && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer     = |(req_valid & req_ready);
  assign grant_id = ID_W'(grant_idx);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = ID_W'((grant_idx + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  mult_pipe #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .LATENCY     (LATENCY),
    .IS_SIGNED   (IS_SIGNED),
    .ID_W        (ID_W)
  ) u_mult_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (~stall),
    .in_valid  (xfer),
    .in_id     (grant_id),
    .in0       (req_in0[grant_idx]),
    .in1       (req_in1[grant_idx]),
    .out_valid (out_valid),
    .out_id    (out_id),
    .product   (product)
  );

  assign out_high = product[2*INPUT_WIDTH-1:INPUT_WIDTH];
  assign out_low  = product[INPUT_WIDTH-1:0];

`ifdef MULT_ARBITER_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (req_valid[i] && req_ready[i] && cnt_q[i] != 16'hFFFF) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: unsigned instance plus a signed twin.
module tb_mult_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready, s_req_ready;
  logic [3:0][15:0] req_in0, req_in1;
  logic             out_valid, s_out_valid;
  logic             out_ready;
  logic [1:0]       out_id, s_out_id;
  logic [15:0]      out_high, out_low, s_out_high, s_out_low;
`ifdef MULT_ARBITER_STATS_EN
  logic [3:0][15:0] grant_count, s_grant_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] rr_in0  [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
  logic [15:0] rr_in1  [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
  logic [15:0] rr_prod [4] = '{16'd10, 16'd40, 16'd90, 16'd160};

  mult_arbiter #(.NUM_REQ(4), .INPUT_WIDTH(16), .LATENCY(3), .IS_SIGNED(1'b0)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_in0     (req_in0),
    .req_in1     (req_in1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_id      (out_id),
    .out_high    (out_high),
    .out_low     (out_low)
`ifdef MULT_ARBITER_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  mult_arbiter #(.NUM_REQ(4), .INPUT_WIDTH(16), .LATENCY(3), .IS_SIGNED(1'b1)) u_dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (s_req_ready),
    .req_in0     (req_in0),
    .req_in1     (req_in1),
    .out_valid   (s_out_valid),
    .out_ready   (out_ready),
    .out_id      (s_out_id),
    .out_high    (s_out_high),
    .out_low     (s_out_low)
`ifdef MULT_ARBITER_STATS_EN
    ,
    .grant_count (s_grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at a falling edge with reset released: that is cycle 0.
  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_rr_operands();
    for (int i = 0; i < 4; i++) begin
      req_in0[i] = rr_in0[i];
      req_in1[i] = rr_in1[i];
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    set_rr_operands();
    @(negedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if ({out_id, out_high, out_low} !== 34'd0) begin
      n_err++; $display("FAIL reset_out_data: got id=%h hi=%h lo=%h expected all 0",
                        out_id, out_high, out_low);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_in0[0] = 16'd300;
    req_in1[0] = 16'd200;
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 0) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 0) begin
        n_cmp++;
        if (req_ready !== 4'b0001) begin
          n_err++; $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
      end else if (c == 3) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_high !== 16'h0000 ||
            out_low !== 16'hEA60) begin
          n_err++; $display("FAIL single_result: got v=%b id=%0d hi=%h lo=%h expected 1 0 0000 EA60",
                            out_valid, out_id, out_high, out_low);
        end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL single_bubble c%0d: got out_valid=%b expected 0", c, out_valid);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int         id;
    apply_reset();
    set_rr_operands();
    for (int c = 0; c < 11; c++) begin
      req_valid = 4'b1111;
      #1;
      exp_rdy = 4'b0001 << (c % 4);
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++; $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready, exp_rdy);
      end
      if (c >= 3) begin
        id = (c - 3) % 4;
        n_cmp++;
        if (out_valid !== 1'b1 || out_id !== 2'(id) || out_high !== 16'd0 ||
            out_low !== rr_prod[id]) begin
          n_err++; $display("FAIL rr_out c%0d: got v=%b id=%0d lo=%h expected 1 %0d %h",
                            c, out_valid, out_id, out_low, id, rr_prod[id]);
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_signed();
    apply_reset();
    req_in0[1] = 16'hFFFE;
    req_in1[1] = 16'h0003;
    for (int c = 0; c < 4; c++) begin
      req_valid = (c == 0) ? 4'b0010 : 4'b0000;
      #1;
      if (c == 0) begin
        n_cmp++;
        if (s_req_ready !== 4'b0010) begin
          n_err++; $display("FAIL signed_grant: got %b expected 0010", s_req_ready);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (s_out_valid !== 1'b1 || s_out_id !== 2'd1 || s_out_high !== 16'hFFFF ||
            s_out_low !== 16'hFFFA) begin
          n_err++; $display("FAIL signed_mul: got v=%b id=%0d hi=%h lo=%h expected 1 1 FFFF FFFA",
                            s_out_valid, s_out_id, s_out_high, s_out_low);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_high !== 16'h0002 ||
            out_low !== 16'hFFFA) begin
          n_err++; $display("FAIL unsigned_mul: got v=%b id=%0d hi=%h lo=%h expected 1 1 0002 FFFA",
                            out_valid, out_id, out_high, out_low);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_rdy;
    int         id;
    apply_reset();
    set_rr_operands();
    for (int c = 0; c < 16; c++) begin
      req_valid = 4'b1111;
      out_ready = !(c >= 3 && c <= 7);
      #1;
      if (c >= 3 && c <= 7) begin
        n_cmp++;
        if (req_ready !== 4'b0000) begin
          n_err++; $display("FAIL bp_ready c%0d: got %b expected 0000", c, req_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_high !== 16'd0 ||
            out_low !== rr_prod[0]) begin
          n_err++; $display("FAIL bp_hold c%0d: got v=%b id=%0d lo=%h expected 1 0 %h",
                            c, out_valid, out_id, out_low, rr_prod[0]);
        end
      end else if (c >= 8) begin
        exp_rdy = 4'b0001 << ((c - 5) % 4);
        id      = (c - 8) % 4;
        n_cmp++;
        if (req_ready !== exp_rdy) begin
          n_err++; $display("FAIL bp_resume_grant c%0d: got %b expected %b", c, req_ready, exp_rdy);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_id !== 2'(id) || out_low !== rr_prod[id]) begin
          n_err++; $display("FAIL bp_drain c%0d: got v=%b id=%0d lo=%h expected 1 %0d %h",
                            c, out_valid, out_id, out_low, id, rr_prod[id]);
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_rr_operands();
    for (int c = 0; c < 4; c++) begin
      req_valid = 4'b1111;
      if (c < 3) @(negedge clk);
    end
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_prefill: got out_valid=%b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0000 || out_id !== 2'd0 ||
        out_high !== 16'd0 || out_low !== 16'd0) begin
      n_err++; $display("FAIL mid_reset: got v=%b rdy=%b id=%0d hi=%h lo=%h expected all 0",
                        out_valid, req_ready, out_id, out_high, out_low);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 0) ? 4'b1111 : 4'b0000;
      #1;
      if (c == 0) begin
        n_cmp++;
        if (req_ready !== 4'b0001) begin
          n_err++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready);
        end
      end else if (c == 3) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_low !== rr_prod[0]) begin
          n_err++; $display("FAIL mid_new_result: got v=%b id=%0d lo=%h expected 1 0 %h",
                            out_valid, out_id, out_low, rr_prod[0]);
        end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL mid_stale c%0d: got out_valid=%b expected 0", c, out_valid);
        end
      end
      @(negedge clk);
    end
  endtask

`ifdef MULT_ARBITER_STATS_EN
  task automatic test_stats();
    apply_reset();
    set_rr_operands();
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 10) ? 4'b0100 : 4'b0001;
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    n_cmp++;
    if (grant_count[2] !== 16'd10 || grant_count[0] !== 16'd3 ||
        grant_count[1] !== 16'd0 || grant_count[3] !== 16'd0) begin
      n_err++; $display("FAIL stats_counts: got %0d %0d %0d %0d expected 3 0 10 0",
                        grant_count[0], grant_count[1], grant_count[2], grant_count[3]);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    req_in0   = '0;
    req_in1   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_signed();
    test_backpressure();
    test_reset_midflight();
`ifdef MULT_ARBITER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one pipelined INPUT_WIDTH x INPUT_WIDTH multiplier among NUM_REQ requesters.
- Uses round-robin arbitration with per-requester valid/ready handshakes.
- Each result returns on a single output channel, tagged with the requester ID and split into high/low halves.
- Sits between multiple datapath clients and the shared multiplier resource; the multiplier itself is the sub-module.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- INPUT_WIDTH, 16, operand width.
- LATENCY, 3, multiplier pipeline depth in cycles (>=1).
- IS_SIGNED, 1'b0, 1 = two's-complement multiply, 0 = unsigned; elaboration-time constant.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_in0  in  NUM_REQ x INPUT_WIDTH  operand A per requester.
- req_in1  in  NUM_REQ x INPUT_WIDTH  operand B per requester.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer accept.
- out_id  out  ID_W  requester index of the result; ID_W = max(1, clog2(NUM_REQ)).
- out_high  out  INPUT_WIDTH  product[2*INPUT_WIDTH-1:INPUT_WIDTH].
- out_low  out  INPUT_WIDTH  product[INPUT_WIDTH-1:0].

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - out_valid=0, out_id=0, out_high=0, out_low=0, req_ready=0 while rst_n=0.
  - RR pointer=0.
  - All pipeline valid bits=0.
- Stall:
  - stall = out_valid & ~out_ready.
  - While stall is high, every pipeline stage holds, the RR pointer holds, and req_ready=0.
- Grant (combinational, same cycle):
  - When stall=0, grant the first requester with req_valid=1, searching from the RR pointer upward modulo NUM_REQ.
  - req_ready[g]=1 for that requester only.
  - Transfer occurs when req_valid&req_ready.
  - req_ready never depends on out_ready except through stall.
- RR pointer: after a transfer from requester g, the pointer becomes (g+1) mod NUM_REQ. With no transfer, it is unchanged.
- Pipeline:
  - A transfer at cycle t produces out_valid=1 at t+LATENCY if there are no stalls; each stall cycle adds one cycle.
  - Throughput is one result per cycle.
  - Results leave in grant order.
  - id travels with the data through the pipeline.
- Arithmetic:
  - Full 2*INPUT_WIDTH product with no truncation.
  - IS_SIGNED=1: both operands are sign-extended and the product is two's complement.
  - IS_SIGNED=0: zero-extended.
- Output hold: once out_valid=1, out_id/out_high/out_low stay stable until out_valid&out_ready.
- Boundaries:
  - All req_valid=0: no grant, and bubbles propagate (out_valid=0 in the matching cycles).
  - out_ready low with the pipeline full: no new grants.
  - Releasing out_ready drains one result per cycle and resumes grants the same cycle.
  - Reset mid-operation: all in-flight results are discarded and the pointer returns to 0.
  - Requester withdrawing req_valid before its grant is legal; no state is retained.

Optional Feature:
- Macro: MULT_ARBITER_STATS_EN.
- Defined:
  - Adds output port grant_count (NUM_REQ x 16).
  - Per-requester transfer counters, saturating at 16'hFFFF.
  - Reset to 0.
  - Increment on the cycle of transfer.
- Undefined: port and counters are absent; no other behaviour changes.

Decomposition:
- Package mult_arbiter_pkg:
  - ID width function clog2-based (min 1).
  - Localparam default widths.
  - Packed struct typedef for a pipeline stage {valid, id, product}; product is parameterized via the module's localparam width.
- Sub-module mult_pipe:
  - Parameters INPUT_WIDTH, LATENCY, IS_SIGNED.
  - Ports: clk, rst_n, en, in_valid, in_id, in0, in1, out_valid, out_id, product.
  - Performs the multiply in stage 1 and carries results through LATENCY registers gated by en (= ~stall).
- mult_arbiter contains the RR grant logic, the pointer register, the stall computation and output splitting.

Test Plan:
- Single request (NUM_REQ=4, LATENCY=3): req0 only, 16'd300 x 16'd200 at cycle 0 -> cycle 3 out_valid=1, out_id=0, out_high=16'h0000, out_low=16'hEA60.
- Round-robin: all four req_valid held high, out_ready=1 -> grants in order 0,1,2,3,0,...; outputs in the same id order, one per cycle, starting cycle 3.
- Signed (IS_SIGNED=1): 16'hFFFE x 16'h0003 -> out_high=16'hFFFF, out_low=16'hFFFA. Same operands with IS_SIGNED=0 -> out_high=16'h0002, out_low=16'hFFFA.
- Backpressure: continuous requests, out_ready=0 for 5 cycles once out_valid rises -> outputs held stable, req_ready=0 throughout; on release, no result lost or duplicated and ids stay in grant order.
- Reset mid-flight: assert rst_n=0 with 3 results in flight -> outputs and req_ready 0 immediately; after release, the first grant goes to requester 0 and no stale out_valid appears.
- MULT_ARBITER_STATS_EN: 10 transfers for req2 and 3 for req0 -> grant_count[2]=10, grant_count[0]=3, others 0.
